xalu_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage beside the main ALU and driven by the main controller's start and XAluOp fields. It generalises the fixed 32-bit, fixed-latency MDU to a configurable operand width and configurable latencies. It adds MADD/MSUB accumulation, a flush input for exception cancellation, and defined divide-by-zero and overflow behaviour. The hazard unit stalls on `busy_any`, and mfhi/mflo read `hi`/`lo` directly.

---
 rtl/xalu_pkg.sv | 21 ++
 rtl/xalu_arith.sv | 39 +++
 rtl/xalu_mdu.sv | 83 ++++++++
 tb/tb_xalu_mdu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// xalu_pkg: op encoding and decode helpers shared by the MDU, controller and hazard unit.
package xalu_pkg;

    localparam logic [2:0] XOP_MULT  = 3'd0;
    localparam logic [2:0] XOP_MULTU = 3'd1;
    localparam logic [2:0] XOP_DIV   = 3'd2;
    localparam logic [2:0] XOP_DIVU  = 3'd3;
    localparam logic [2:0] XOP_MTHI  = 3'd4;
    localparam logic [2:0] XOP_MTLO  = 3'd5;
    localparam logic [2:0] XOP_MADD  = 3'd6;
    localparam logic [2:0] XOP_MSUB  = 3'd7;

    function automatic logic xop_is_long(input logic [2:0] op);
        return op != XOP_MTHI && op != XOP_MTLO;
    endfunction

    function automatic logic xop_is_div(input logic [2:0] op);
        return op == XOP_DIV || op == XOP_DIVU;
    endfunction

endpackage

// File: rtl/xalu_arith.sv
// xalu_arith: combinational multiply/divide producing the 2*WIDTH {hi, lo} result.
module xalu_arith
    import xalu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] res_o,
    output logic               dz_o
);

    logic                      ovf;
    logic [WIDTH-1:0]          bs;
    logic [WIDTH-1:0]          qu;
    logic [WIDTH-1:0]          ru;
    logic signed [WIDTH-1:0]   qs;
    logic signed [WIDTH-1:0]   rs;
    logic [2*WIDTH-1:0]        pu;
    logic signed [2*WIDTH-1:0] ps;

    // Divide-by-zero and MIN/-1 both divide by 1 instead: MIN/1 already gives lo=MIN, hi=0
    always_comb begin
        dz_o  = xop_is_div(op_i) && b_i == '0;
        ovf   = op_i == XOP_DIV && a_i == {1'b1, {(WIDTH-1){1'b0}}} && b_i == '1;
        bs    = (dz_o || ovf) ? WIDTH'(1) : b_i;
        qs    = $signed(a_i) / $signed(bs);
        rs    = $signed(a_i) % $signed(bs);
        qu    = a_i / bs;
        ru    = a_i % bs;
        pu    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        ps    = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
        res_o = op_i == XOP_MULTU ? pu :
                op_i == XOP_DIV   ? {rs, qs} :
                op_i == XOP_DIVU  ? {ru, qu} : ps;
    end

endmodule

// File: rtl/xalu_mdu.sv
// xalu_mdu: multi-cycle multiply/divide unit with HI/LO, MADD/MSUB accumulate and flush.
module xalu_mdu
    import xalu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             busy_any_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0]        count_q, count_d;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   pend_q, res, hl, nxt;
    logic                 dz_q, dz, done_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 idle, issue, long_op, commit;

    xalu_arith #(.WIDTH(WIDTH)) u_arith (
        .op_i (op_i),
        .a_i  (a_i),
        .b_i  (b_i),
        .res_o(res),
        .dz_o (dz)
    );

    always_comb begin
        idle    = count_q == '0;
        long_op = xop_is_long(op_i);
        issue   = idle && start_i && !flush_i;
        commit  = count_q == CW'(1) && !flush_i;
        hl      = {hi_q, lo_q};
        nxt     = op_q == XOP_MADD ? hl + pend_q :
                  op_q == XOP_MSUB ? hl - pend_q : pend_q;
        count_d = flush_i            ? '0 :
                  issue && long_op   ? (xop_is_div(op_i) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                  idle               ? count_q : count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            op_q    <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            count_q <= count_d;
            done_q  <= commit;
            if (issue && long_op) begin
                pend_q <= res;
                dz_q   <= dz;
                op_q   <= op_i;
            end
            if (issue && op_i == XOP_MTHI) hi_q <= a_i;
            if (issue && op_i == XOP_MTLO) lo_q <= a_i;
            if (commit && !dz_q) {hi_q, lo_q} <= nxt;
        end
    end

    assign busy_o     = count_q != '0;
    assign busy_any_o = busy_o || (start_i && long_op);
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_xalu_mdu.sv
// tb_xalu_mdu: table-driven and hand-sequenced checks of xalu_mdu at two parameter sets.
module tb_xalu_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, busy_any, done;
    logic [31:0] hi, lo;

    logic        s1 = 1'b0, f1 = 1'b0;
    logic [2:0]  op1 = '0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        busy1, busy_any1, done1;
    logic [15:0] hi1, lo1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xalu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy), .busy_any_o(busy_any), .done_o(done),
        .hi_o(hi), .lo_o(lo)
    );

    xalu_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(s1), .op_i(op1), .a_i(a1), .b_i(b1),
        .flush_i(f1), .busy_o(busy1), .busy_any_o(busy_any1), .done_o(done1),
        .hi_o(hi1), .lo_o(lo1)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, ph, pl, eh, el;
        int          cyc;
    } vec_t;

    vec_t vec[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; a = v;
        #1 chk("mt busy_any", busy_any, 0);
        @(negedge clk);
        start = 1'b0;
        chk("mt busy", busy, 0);
        chk("mt done", done, 0);
        chk(o == 3'd4 ? "mthi value" : "mtlo value", o == 3'd4 ? hi : lo, v);
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input int ec);
        int n, dn;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        #1 chk({nm, " busy_any"}, busy_any, 1);
        @(negedge clk);
        start = 1'b0;
        n = 0; dn = 0;
        while (busy && n < 100) begin
            n++; dn += int'(done);
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, n, ec);
        chk({nm, " done early"}, dn, 0);
        chk({nm, " done"}, done, 1);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        @(negedge clk);
        chk({nm, " done end"}, done, 0);
    endtask

    task automatic idle_watch(input string nm, input int cycles, input logic [31:0] eh, input logic [31:0] el);
        int dn;
        dn = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            dn += int'(done) + int'(busy);
        end
        chk({nm, " no done/busy"}, dn, 0);
        chk({nm, " hi kept"}, hi, eh);
        chk({nm, " lo kept"}, lo, el);
    endtask

    initial begin
        vec[0]  = '{"mult",     3'd0, 32'hFFFFFFFD, 32'd7,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vec[1]  = '{"multu",    3'd1, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFE, 5};
        vec[2]  = '{"divu",     3'd3, 32'd100,      32'd7,        32'h0,  32'h0,  32'd2,        32'd14,       10};
        vec[3]  = '{"div neg",  3'd2, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vec[4]  = '{"div ovf",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h0,        32'h80000000, 10};
        vec[5]  = '{"div negb", 3'd2, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'd1,        32'hFFFFFFFD, 10};
        vec[6]  = '{"divu big", 3'd3, 32'hFFFFFFFF, 32'h10,       32'h0,  32'h0,  32'hF,        32'h0FFFFFFF, 10};
        vec[7]  = '{"div by 0", 3'd2, 32'd5,        32'd0,        32'h11, 32'h22, 32'h11,       32'h22,       10};
        vec[8]  = '{"madd",     3'd6, 32'd3,        32'd4,        32'h0,  32'h5,  32'h0,        32'd17,       5};
        vec[9]  = '{"msub",     3'd7, 32'd2,        32'd10,       32'h0,  32'd17, 32'hFFFFFFFF, 32'hFFFFFFFD, 5};
        vec[10] = '{"madd neg", 3'd6, 32'hFFFFFFFF, 32'd1,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 5};

        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy_any", busy_any, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            mt(3'd4, vec[i].ph);
            mt(3'd5, vec[i].pl);
            run_op(vec[i].name, vec[i].op, vec[i].a, vec[i].b, vec[i].eh, vec[i].el, vec[i].cyc);
        end

        // back-to-back: second start issued in the done cycle
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        chk("b2b first done", done, 1);
        chk("b2b first lo", lo, 6);
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("b2b second busy", busy, 1);
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        chk("b2b second lo", lo, 25);
        chk("b2b second hi", hi, 0);

        // flush in the third busy cycle
        mt(3'd4, 32'hAA);
        mt(3'd5, 32'hBB);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush busy before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy drop", busy, 0);
        idle_watch("flush mid", 8, 32'hAA, 32'hBB);

        // flush at the commit edge
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush commit done", done, 0);
        idle_watch("flush commit", 8, 32'hAA, 32'hBB);

        // flush coincident with MTLO
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h99; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush mtlo lo", lo, 32'hBB);

        // reset during DIV cycle 4
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid busy", busy, 0);
        chk("rst mid hi", hi, 0);
        chk("rst mid lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch("rst mid", 12, 32'h0, 32'h0);

        // WIDTH=16, MULT_CYCLES=1
        @(negedge clk);
        s1 = 1'b1; op1 = 3'd0; a1 = 16'hFFFD; b1 = 16'd7;
        #1 chk("w16 busy_any", busy_any1, 1);
        @(negedge clk);
        s1 = 1'b0;
        chk("w16 busy", busy1, 1);
        chk("w16 done early", done1, 0);
        @(negedge clk);
        chk("w16 busy fall", busy1, 0);
        chk("w16 done", done1, 1);
        chk("w16 hi", hi1, 16'hFFFF);
        chk("w16 lo", lo1, 16'hFFEB);
        @(negedge clk);
        chk("w16 done end", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
